gmii_tx_framer: RTL and testbench

- Transmit-side Ethernet framer; counterpart to the RGMII/GMII receive path.
- Accepts a payload byte stream with valid/ready/last. Emits a complete GMII frame on an 8-bit SDR interface: preamble, SFD, payload, zero padding, CRC32 FCS, and a minimum inter-frame gap.
- Sits between the packet builder and the existing RGMII DDR output stage, which splits txd into nibbles.

---
 rtl/gmii_tx_framer.sv | 173 +++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, CRC32 FCS, inter-frame gap.
// All GMII outputs are registered; s_ready is decoded from the current state.
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       tx_done,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, FLUSH, IFG} state_t;

  localparam logic [16:0] MIN_LEN = 17'(MIN_PAYLOAD);
  localparam logic [7:0]  PRE_LEN = 8'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_LEN = 8'(IFG_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        tx_done_q, tx_done_d;

  logic [16:0] pcnt_nxt;
  logic [15:0] pcnt_sat;
  logic [31:0] fcs;

  // Reflected CRC32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    crc_d     = crc_q;
    txd_d     = 8'h00;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    tx_done_d = 1'b0;
    pcnt_nxt  = {1'b0, pcnt_q} + 17'd1;
    pcnt_sat  = (&pcnt_q) ? pcnt_q : pcnt_q + 16'd1;
    fcs       = ~crc_q;

    unique case (state_q)
      IDLE: begin
        crc_d  = 32'hFFFFFFFF;
        pcnt_d = 16'd0;
        cnt_d  = 8'd0;
        if (s_valid) begin
          state_d = PRE;
          txd_d   = 8'h55;
          tx_en_d = 1'b1;
          cnt_d   = 8'd1;
        end
      end
      PRE: begin
        tx_en_d = 1'b1;
        if (cnt_q == PRE_LEN) begin
          txd_d   = 8'hD5;
          state_d = DATA;
          cnt_d   = 8'd0;
        end else begin
          txd_d = 8'h55;
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        tx_en_d = 1'b1;
        if (s_valid) begin
          txd_d  = s_data;
          crc_d  = crc_byte(crc_q, s_data);
          pcnt_d = pcnt_sat;
          if (s_last) begin
            cnt_d   = 8'd0;
            state_d = (pcnt_nxt < MIN_LEN) ? PAD : FCS;
          end
        end else begin
          // Upstream starved mid-frame: poison the frame and swallow the rest.
          tx_er_d = 1'b1;
          state_d = FLUSH;
        end
      end
      PAD: begin
        tx_en_d = 1'b1;
        crc_d   = crc_byte(crc_q, 8'h00);
        pcnt_d  = pcnt_sat;
        if (pcnt_nxt >= MIN_LEN) begin
          state_d = FCS;
          cnt_d   = 8'd0;
        end
      end
      FCS: begin
        tx_en_d = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        case (cnt_q[1:0])
          2'd0:    txd_d = fcs[7:0];
          2'd1:    txd_d = fcs[15:8];
          2'd2:    txd_d = fcs[23:16];
          default: txd_d = fcs[31:24];
        endcase
        if (cnt_q[1:0] == 2'd3) begin
          tx_done_d = 1'b1;
          state_d   = IFG;
          cnt_d     = 8'd0;
        end
      end
      FLUSH: begin
        if (s_valid && s_last) begin
          state_d = IFG;
          cnt_d   = 8'd0;
        end
      end
      IFG: begin
        if (cnt_q == IFG_LEN - 8'd1) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      pcnt_q    <= 16'd0;
      crc_q     <= 32'hFFFFFFFF;
      txd_q     <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      crc_q     <= crc_d;
      txd_q     <= txd_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign s_ready = !rst && ((state_q == DATA) || (state_q == FLUSH));
  assign busy    = (state_q != IDLE);
  assign txd     = txd_q;
  assign tx_en   = tx_en_q;
  assign tx_er   = tx_er_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: expected GMII bytes are queued as stimulus
// is planned and popped by a negedge monitor whenever tx_en is high.
module tb_gmii_tx_framer;

  localparam int PRE = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic [7:0] txd;
  logic       tx_en, tx_er, tx_done, busy;

  logic [7:0] s_data0;
  logic       s_valid0, s_last0, s_ready0;
  logic [7:0] txd0;
  logic       tx_en0, tx_er0, tx_done0, busy0;

  always #4 clk = ~clk;

  gmii_tx_framer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .txd(txd), .tx_en(tx_en), .tx_er(tx_er),
    .tx_done(tx_done), .busy(busy)
  );

  gmii_tx_framer #(.MIN_PAYLOAD(0)) dut0 (
    .clk(clk), .rst(rst), .s_data(s_data0), .s_valid(s_valid0), .s_last(s_last0),
    .s_ready(s_ready0), .txd(txd0), .tx_en(tx_en0), .tx_er(tx_er0),
    .tx_done(tx_done0), .busy(busy0)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       er;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frm_q[$];
  logic [7:0] pl_q[$];
  logic       last_q[$];
  int         hold_q[$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   en_len = 0;
  int   run = 0;
  int   last_done_cyc = -1000;
  int   last_gap = 0;
  int   rdy_cnt = 0;
  logic prev_en = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    cyc++;
    if (s_ready === 1'b1) rdy_cnt++;
    if (tx_en === 1'b1) begin
      if (!prev_en) last_gap = cyc - last_done_cyc;
      run++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: cyc=%0d txd=%02h er=%b done=%b, required no transmission",
                 cyc, txd, tx_er, tx_done);
      end else begin
        mon_e = exp_q.pop_front();
        if ({txd, tx_er, tx_done} !== mon_e) begin
          n_fail++;
          $display("FAIL tx_byte: cyc=%0d got txd=%02h er=%b done=%b, required txd=%02h er=%b done=%b",
                   cyc, txd, tx_er, tx_done, mon_e.d, mon_e.er, mon_e.done);
        end
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      prev_en = 1'b1;
    end else begin
      if (prev_en) en_len = run;
      run = 0;
      prev_en = 1'b0;
      n_checks++;
      if (tx_done === 1'b1 || tx_er === 1'b1) begin
        n_fail++;
        $display("FAIL idle_ctrl: cyc=%0d tx_done=%b tx_er=%b while tx_en low, required 0/0",
                 cyc, tx_done, tx_er);
      end
    end
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Queue frm_q for the driver and push the full expected GMII frame.
  task automatic add_frame(input int min_pl);
    logic [31:0] c;
    int n;
    c = 32'hFFFFFFFF;
    n = frm_q.size();
    for (int i = 0; i < PRE; i++) exp_q.push_back(exp_t'({8'h55, 2'b00}));
    exp_q.push_back(exp_t'({8'hD5, 2'b00}));
    for (int i = 0; i < n; i++) begin
      pl_q.push_back(frm_q[i]);
      last_q.push_back(i == n - 1);
      hold_q.push_back(0);
      exp_q.push_back(exp_t'({frm_q[i], 2'b00}));
      c = crc_step(c, frm_q[i]);
    end
    for (int i = n; i < min_pl; i++) begin
      exp_q.push_back(exp_t'({8'h00, 2'b00}));
      c = crc_step(c, 8'h00);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_t'({c[8*k +: 8], 1'b0, k == 3}));
  endtask

  task automatic clear_drv();
    pl_q.delete();
    last_q.delete();
    hold_q.delete();
  endtask

  // Push pl_q into the DUT; abort_at >= 0 asserts rst while that byte index is offered.
  task automatic drive_stream(input int abort_at);
    int   guard;
    int   acc_n;
    logic acc;
    guard = 0;
    acc_n = 0;
    while (pl_q.size() > 0 && guard < 5000) begin
      if (acc_n == abort_at) begin
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = pl_q[0];
        s_last = last_q[0];
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_no_accept: s_ready=%b during reset, required 0", s_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({txd, tx_en, tx_er, tx_done, busy, s_ready} !== 13'h0) begin
          n_fail++;
          $display("FAIL rst_midframe: txd=%02h en=%b er=%b done=%b busy=%b rdy=%b, required all 0",
                   txd, tx_en, tx_er, tx_done, busy, s_ready);
        end
        rst = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        clear_drv();
        return;
      end
      if (hold_q[0] > 0) begin
        s_valid = 1'b0;
        s_last = 1'b0;
        hold_q[0] = hold_q[0] - 1;
        @(posedge clk); #1;
        guard++;
        continue;
      end
      s_valid = 1'b1;
      s_data = pl_q[0];
      s_last = last_q[0];
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      guard++;
      if (acc === 1'b1) begin
        void'(pl_q.pop_front());
        void'(last_q.pop_front());
        void'(hold_q.pop_front());
        acc_n++;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    n_checks++;
    if (pl_q.size() != 0) begin
      n_fail++;
      $display("FAIL drive_timeout: %0d bytes left unaccepted, required 0", pl_q.size());
      clear_drv();
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, t);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hAA;
    s_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({txd, tx_en, tx_er, tx_done, busy, s_ready} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_state: txd=%02h en=%b er=%b done=%b busy=%b rdy=%b, required all 0",
               txd, tx_en, tx_er, tx_done, busy, s_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic test_short_frame();
    int d0;
    d0 = done_cnt;
    frm_q = '{8'hA5};
    add_frame(60);
    drive_stream(-1);
    wait_idle();
    check_int("short_en_len", en_len, 72);
    check_int("short_done_cnt", done_cnt - d0, 1);
    check_int("short_exp_left", exp_q.size(), 0);
  endtask

  task automatic test_crc_vector();
    string      msg;
    logic [7:0] got[$];
    logic [7:0] fcs_req[4];
    msg = "123456789";
    fcs_req = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    fork
      begin
        int i;
        int g;
        logic acc;
        i = 0;
        g = 0;
        while (i < 9 && g < 200) begin
          s_valid0 = 1'b1;
          s_data0 = msg[i];
          s_last0 = (i == 8);
          @(negedge clk);
          acc = s_ready0;
          @(posedge clk); #1;
          g++;
          if (acc === 1'b1) i++;
        end
        s_valid0 = 1'b0;
        s_last0 = 1'b0;
      end
      begin
        for (int t = 0; t < 200; t++) begin
          @(negedge clk);
          if (tx_en0 === 1'b1) got.push_back(txd0);
          if (tx_done0 === 1'b1) break;
        end
      end
    join
    check_int("crc_en_len", got.size(), 21);
    if (got.size() == 21) begin
      for (int k = 0; k < 9; k++) begin
        n_checks++;
        if (got[8+k] !== msg[k]) begin
          n_fail++;
          $display("FAIL crc_payload[%0d]: got %02h, required %02h", k, got[8+k], msg[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[17+k] !== fcs_req[k]) begin
          n_fail++;
          $display("FAIL crc_fcs[%0d]: got %02h, required %02h", k, got[17+k], fcs_req[k]);
        end
      end
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_long_frame();
    frm_q.delete();
    for (int i = 0; i < 100; i++) frm_q.push_back(8'(i));
    add_frame(60);
    rdy_cnt = 0;
    drive_stream(-1);
    wait_idle();
    check_int("long_ready_cycles", rdy_cnt, 100);
    check_int("long_en_len", en_len, 112);
    check_int("long_exp_left", exp_q.size(), 0);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    for (int f = 0; f < 2; f++) begin
      frm_q.delete();
      for (int i = 0; i < 64; i++) frm_q.push_back(8'($urandom_range(0, 255)));
      add_frame(60);
    end
    drive_stream(-1);
    wait_idle();
    check_int("b2b_done_cnt", done_cnt - d0, 2);
    check_int("b2b_gap", last_gap, 13);
    check_int("b2b_en_len", en_len, 76);
    check_int("b2b_exp_left", exp_q.size(), 0);
  endtask

  task automatic test_underrun();
    int d0;
    int b;
    d0 = done_cnt;
    for (int i = 0; i < PRE; i++) exp_q.push_back(exp_t'({8'h55, 2'b00}));
    exp_q.push_back(exp_t'({8'hD5, 2'b00}));
    for (int i = 0; i < 25; i++) begin
      pl_q.push_back(8'(8'h30 + i));
      last_q.push_back(i == 24);
      hold_q.push_back(i == 20 ? 3 : 0);
      if (i < 20) exp_q.push_back(exp_t'({8'(8'h30 + i), 2'b00}));
    end
    exp_q.push_back(exp_t'({8'h00, 1'b1, 1'b0}));
    drive_stream(-1);
    b = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (busy === 1'b1) b++;
      else break;
    end
    check_int("underrun_ifg_busy", b, 12);
    check_int("underrun_no_done", done_cnt - d0, 0);
    check_int("underrun_exp_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int d0;
    frm_q.delete();
    for (int i = 0; i < 64; i++) frm_q.push_back(8'(8'hC0 ^ i));
    add_frame(60);
    drive_stream(29);
    check_int("rst_exp_left", exp_q.size(), 39);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    frm_q = '{8'h12, 8'h34, 8'h56};
    add_frame(60);
    drive_stream(-1);
    wait_idle();
    check_int("post_rst_en_len", en_len, 72);
    check_int("post_rst_done", done_cnt - d0, 1);
    check_int("post_rst_exp_left", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = 8'h00;
    s_valid0 = 1'b0;
    s_last0 = 1'b0;
    s_data0 = 8'h00;
    test_reset();
    test_short_frame();
    test_crc_vector();
    test_long_frame();
    test_back_to_back();
    test_underrun();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
